// File: rtl/cnn_pkg.sv
// Shared definitions for the conv window read-address generator.
// Holds the default address width, the scan FSM encoding, and the
// elaboration-time helpers for output dimensions and per-port offsets.
package cnn_pkg;

  localparam int ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of window positions along one axis.
  function automatic int out_dim(input int img, input int k, input int stride);
    return (img - k) / stride + 1;
  endfunction

  // Fixed address offset of read port (r*K + c) relative to the window origin.
  function automatic int port_offset(input int port, input int k, input int img_w);
    return (port / k) * img_w + (port % k);
  endfunction

endpackage

// File: rtl/conv_window_addr_gen_win_pos_counter.sv
// Window position tracker.
// Holds the output row/col counters and the row_base / col_off address
// accumulators, and provides the next-state values so the parent can
// register the next window's addresses in the same cycle it advances.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   clear           restart the scan at (0,0)
//   advance         step to the next window (row-major, wraps at frame end)
//   row, col        registered position of the current window
//   row_base_next   next value of the row accumulator (row*STRIDE*IMG_W)
//   col_off_next    next value of the column accumulator (col*STRIDE)
//   last_next       the next position is the final window of the frame
module win_pos_counter
  import cnn_pkg::*;
#(
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32,
  parameter int K          = 5,
  parameter int STRIDE     = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  advance,
  output logic [CNT_WIDTH-1:0]  row,
  output logic [CNT_WIDTH-1:0]  col,
  output logic [ADDR_WIDTH-1:0] row_base_next,
  output logic [ADDR_WIDTH-1:0] col_off_next,
  output logic                  last_next
);

  localparam int OUT_W = out_dim(IMG_W, K, STRIDE);
  localparam int OUT_H = out_dim(IMG_H, K, STRIDE);

  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(STRIDE * IMG_W);
  localparam logic [ADDR_WIDTH-1:0] COL_STEP = ADDR_WIDTH'(STRIDE);
  localparam logic [CNT_WIDTH-1:0]  COL_MAX  = CNT_WIDTH'(OUT_W - 1);
  localparam logic [CNT_WIDTH-1:0]  ROW_MAX  = CNT_WIDTH'(OUT_H - 1);

  logic [ADDR_WIDTH-1:0] row_base;
  logic [ADDR_WIDTH-1:0] col_off;
  logic [CNT_WIDTH-1:0]  row_next;
  logic [CNT_WIDTH-1:0]  col_next;

  always_comb begin
    row_next      = row;
    col_next      = col;
    row_base_next = row_base;
    col_off_next  = col_off;
    if (clear) begin
      row_next      = '0;
      col_next      = '0;
      row_base_next = '0;
      col_off_next  = '0;
    end else if (advance) begin
      if (col == COL_MAX) begin
        col_next     = '0;
        col_off_next = '0;
        if (row == ROW_MAX) begin
          row_next      = '0;
          row_base_next = '0;
        end else begin
          row_next      = row + CNT_WIDTH'(1);
          row_base_next = row_base + ROW_STEP;
        end
      end else begin
        col_next     = col + CNT_WIDTH'(1);
        col_off_next = col_off + COL_STEP;
      end
    end
  end

  assign last_next = (row_next == ROW_MAX) && (col_next == COL_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row      <= '0;
      col      <= '0;
      row_base <= '0;
      col_off  <= '0;
    end else begin
      row      <= row_next;
      col      <= col_next;
      row_base <= row_base_next;
      col_off  <= col_off_next;
    end
  end

endmodule

// File: rtl/conv_window_addr_gen.sv
// Read-side address generator: slides a KxK window over an IMG_W x IMG_H
// feature map stored from base_addr and presents the K*K read addresses of
// each window to the conv core with a valid/ready handshake.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        pulse that begins a frame scan (ignored unless idle)
//   base_addr    address of pixel (0,0), captured on an accepted start
//   rd_addr_NP   packed window addresses, port r*K+c at slice (r*K+c)
//   win_valid    window addresses are valid
//   win_ready    conv core accepts the window this cycle
//   win_row/col  output position of the presented window
//   win_last     presented window is the last of the frame
//   busy         scan in progress (not idle)
//   done         one-cycle pulse after the last window is accepted
module conv_window_addr_gen
  import cnn_pkg::*;
#(
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32,
  parameter int K          = 5,
  parameter int STRIDE     = 1,
  parameter int ADDR_WIDTH = cnn_pkg::ADDR_WIDTH,
  parameter int PORT_NUM   = 25,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [ADDR_WIDTH-1:0]          base_addr,
  output logic [PORT_NUM*ADDR_WIDTH-1:0] rd_addr_NP,
  output logic                           win_valid,
  input  logic                           win_ready,
  output logic [CNT_WIDTH-1:0]           win_row,
  output logic [CNT_WIDTH-1:0]           win_col,
  output logic                           win_last,
  output logic                           busy,
  output logic                           done
);

  if (K > IMG_W || K > IMG_H) begin : g_bad_window
    $fatal(1, "conv_window_addr_gen: window K larger than the feature map");
  end
  if (((IMG_W - K) % STRIDE) != 0 || ((IMG_H - K) % STRIDE) != 0) begin : g_bad_stride
    $fatal(1, "conv_window_addr_gen: STRIDE does not tile the feature map");
  end
  if (PORT_NUM != K * K) begin : g_bad_ports
    $fatal(1, "conv_window_addr_gen: PORT_NUM must equal K*K");
  end

  state_t                        state;
  logic [ADDR_WIDTH-1:0]         base_q;
  logic                          accept;
  logic                          handshake;
  logic                          load;
  logic [ADDR_WIDTH-1:0]         row_base_next;
  logic [ADDR_WIDTH-1:0]         col_off_next;
  logic [ADDR_WIDTH-1:0]         win_base;
  logic [ADDR_WIDTH-1:0]         pos_next;
  logic                          last_next;
  logic [PORT_NUM*ADDR_WIDTH-1:0] addr_next;

  assign accept    = (state == IDLE) && start;
  assign handshake = (state == RUN) && win_valid && win_ready;
  // The final handshake leaves the addresses of the last window in place.
  assign load      = accept || (handshake && !win_last);

  win_pos_counter #(
    .IMG_W      (IMG_W),
    .IMG_H      (IMG_H),
    .K          (K),
    .STRIDE     (STRIDE),
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_pos (
    .clk           (clk),
    .rst           (rst),
    .clear         (accept),
    .advance       (handshake),
    .row           (win_row),
    .col           (win_col),
    .row_base_next (row_base_next),
    .col_off_next  (col_off_next),
    .last_next     (last_next)
  );

  // On the start cycle the base register is not loaded yet, so use the port.
  assign win_base = accept ? base_addr : base_q;
  assign pos_next = win_base + row_base_next + col_off_next;

  for (genvar i = 0; i < PORT_NUM; i++) begin : g_port
    localparam logic [ADDR_WIDTH-1:0] OFFSET = ADDR_WIDTH'(port_offset(i, K, IMG_W));
    assign addr_next[i*ADDR_WIDTH +: ADDR_WIDTH] = pos_next + OFFSET;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      base_q     <= '0;
      rd_addr_NP <= '0;
      win_valid  <= 1'b0;
      win_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      if (load) begin
        rd_addr_NP <= addr_next;
      end
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            base_q    <= base_addr;
            win_valid <= 1'b1;
            win_last  <= last_next;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (handshake) begin
            if (win_last) begin
              win_valid <= 1'b0;
              win_last  <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              win_last <= last_next;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
